// File: rtl/delay_pipe_pkg.sv
// Shared constants, the stage record layout and the constant-width helper
// used to size the delay_pipe select and counter ports.
package delay_pipe_pkg;

    localparam int MAX_WIDTH = 32;
    localparam int MAX_DEPTH = 16;

    typedef struct packed {
        logic                 valid;
        logic [MAX_WIDTH-1:0] data;
    } stage_rec_t;

    // Ceiling log2. An argument of 0 or 1 returns 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/delay_stage.sv
// One pipe stage: a {valid, data} register that can hold, advance or clear.
module delay_stage #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           flush,
    input  logic [WIDTH:0] d,
    output logic [WIDTH:0] q
);

    logic [WIDTH:0] q_reg;

    // flush wins over en so that a flushed cycle never captures its input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else if (flush) begin
            q_reg <= '0;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/delay_pipe.sv
// Enable-gated delay line with valid qualifiers, a selectable tap, per-bit
// edge detection on the output word and a registered count of live stages.
module delay_pipe
    import delay_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int SW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH),
    localparam int CW = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic [SW-1:0]    tap_sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] tap_data,
    output logic             tap_valid,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [CW-1:0]    count
);

    logic [WIDTH:0]   stage_d [DEPTH];
    logic [WIDTH:0]   stage_q [DEPTH];
    logic [DEPTH-1:0] valid_next;
    logic [WIDTH-1:0] hist_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign stage_d[gi] = {in_valid, in_data};
            end else begin : g_body
                assign stage_d[gi] = stage_q[gi-1];
            end

            delay_stage #(
                .WIDTH(WIDTH)
            ) u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (en),
                .flush (flush),
                .d     (stage_d[gi]),
                .q     (stage_q[gi])
            );

            // Valid bit each stage will hold after this edge
            assign valid_next[gi] = flush ? 1'b0
                                  : (en ? stage_d[gi][WIDTH] : stage_q[gi][WIDTH]);
        end
    endgenerate

    // Counting the post-edge valid bits keeps count in step with the stages
    always_comb begin
        count_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_next = count_next + CW'(valid_next[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_reg  <= '0;
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
            if (flush) begin
                hist_reg <= '0;
            end else if (en) begin
                hist_reg <= stage_q[DEPTH-1][WIDTH-1:0];
            end
        end
    end

    // Out-of-range selects fall through to zero
    always_comb begin
        tap_data  = '0;
        tap_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap_sel == SW'(i)) begin
                tap_valid = stage_q[i][WIDTH];
                tap_data  = stage_q[i][WIDTH-1:0];
            end
        end
    end

    assign out_data  = stage_q[DEPTH-1][WIDTH-1:0];
    assign out_valid = stage_q[DEPTH-1][WIDTH];
    assign rise      = out_data & ~hist_reg;
    assign fall      = ~out_data & hist_reg;
    assign count     = count_reg;

endmodule

// File: tb/tb_delay_pipe.sv
// Directed bench for delay_pipe: DEPTH 2, 4 and 3 instances share one
// stimulus stream; expected values are hand-computed constants.
module tb_delay_pipe;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       flush;
    logic [7:0] in_data;
    logic       in_valid;

    logic       tap_sel2;
    logic [7:0] out_data2, tap_data2, rise2, fall2;
    logic       out_valid2, tap_valid2;
    logic [1:0] count2;

    logic [1:0] tap_sel4;
    logic [7:0] out_data4, tap_data4, rise4, fall4;
    logic       out_valid4, tap_valid4;
    logic [2:0] count4;

    logic [1:0] tap_sel3;
    logic [7:0] out_data3, tap_data3, rise3, fall3;
    logic       out_valid3, tap_valid3;
    logic [1:0] count3;

    int n_cmp;
    int n_err;

    delay_pipe #(.WIDTH(8), .DEPTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .tap_sel(tap_sel2),
        .out_data(out_data2), .out_valid(out_valid2),
        .tap_data(tap_data2), .tap_valid(tap_valid2),
        .rise(rise2), .fall(fall2), .count(count2)
    );

    delay_pipe #(.WIDTH(8), .DEPTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .tap_sel(tap_sel4),
        .out_data(out_data4), .out_valid(out_valid4),
        .tap_data(tap_data4), .tap_valid(tap_valid4),
        .rise(rise4), .fall(fall4), .count(count4)
    );

    delay_pipe #(.WIDTH(8), .DEPTH(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .tap_sel(tap_sel3),
        .out_data(out_data3), .out_valid(out_valid3),
        .tap_data(tap_data3), .tap_valid(tap_valid3),
        .rise(rise3), .fall(fall3), .count(count3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] d, input logic v);
        in_data  = d;
        in_valid = v;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        flush    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        tap_sel2 = 1'b0;
        tap_sel4 = 2'd0;
        tap_sel3 = 2'd0;

        // Reset state
        step(); step();
        check("rst_out_data",  32'(out_data2),  32'h0);
        check("rst_out_valid", 32'(out_valid2), 32'h0);
        check("rst_count",     32'(count2),     32'h0);
        check("rst_tap",       32'({tap_valid2, tap_data2}), 32'h0);
        check("rst_rise_fall", 32'({rise2, fall2}), 32'h0);
        rst_n = 1'b1;
        step();

        // Single valid word through DEPTH=2
        en = 1'b1;
        drive(8'hA5, 1'b1);
        step();
        drive(8'h00, 1'b0);
        check("lat_c1_count",     32'(count2),     32'd1);
        check("lat_c1_out_valid", 32'(out_valid2), 32'h0);
        step();
        check("lat_c2_out_data",  32'(out_data2),  32'hA5);
        check("lat_c2_out_valid", 32'(out_valid2), 32'h1);
        check("lat_c2_count",     32'(count2),     32'd1);
        step();
        check("lat_c3_count",     32'(count2),     32'd0);
        check("lat_c3_out_valid", 32'(out_valid2), 32'h0);
        check("lat_c3_fall",      32'(fall2),      32'hA5);

        // Stall holds everything, resume loses nothing
        drive(8'h11, 1'b1); step();
        drive(8'h22, 1'b1); step();
        drive(8'h33, 1'b1); step();
        check("pre_hold_out", 32'(out_data2), 32'h22);
        en = 1'b0;
        drive(8'h44, 1'b1);
        for (int i = 0; i < 5; i++) step();
        check("hold_out_data", 32'(out_data2), 32'h22);
        check("hold_count",    32'(count2),    32'd2);
        check("hold_tap0",     32'(tap_data2), 32'h33);
        en = 1'b1;
        step();
        drive(8'h00, 1'b0);
        check("resume_out1", 32'(out_data2), 32'h33);
        step();
        check("resume_out2", 32'(out_data2), 32'h44);

        // Flush a full pipe while a valid word is presented
        drive(8'h66, 1'b1); step();
        drive(8'h77, 1'b1); step();
        check("full_count", 32'(count2), 32'd2);
        flush = 1'b1;
        drive(8'h99, 1'b1);
        step();
        flush = 1'b0;
        drive(8'h00, 1'b0);
        check("flush_count",     32'(count2),     32'd0);
        check("flush_out_valid", 32'(out_valid2), 32'h0);
        check("flush_out_data",  32'(out_data2),  32'h0);
        check("flush_rise_fall", 32'({rise2, fall2}), 32'h0);
        step(); step();
        check("flush_no_emerge", 32'({out_valid2, out_data2}), 32'h0);

        // Known fill for the tap sweep
        flush = 1'b1; step(); flush = 1'b0;
        drive(8'hA1, 1'b1); step();
        drive(8'hB2, 1'b0); step();
        drive(8'hC3, 1'b1); step();
        drive(8'hD4, 1'b1); step();
        en = 1'b0;
        drive(8'h00, 1'b0);
        tap_sel4 = 2'd0; #1;
        check("tap4_s0", 32'({tap_valid4, tap_data4}), 32'h1D4);
        tap_sel4 = 2'd1; #1;
        check("tap4_s1", 32'({tap_valid4, tap_data4}), 32'h1C3);
        tap_sel4 = 2'd2; #1;
        check("tap4_s2", 32'({tap_valid4, tap_data4}), 32'h0B2);
        tap_sel4 = 2'd3; #1;
        check("tap4_s3", 32'({tap_valid4, tap_data4}), 32'h1A1);
        check("tap4_count", 32'(count4), 32'd3);
        check("tap4_out",   32'({out_valid4, out_data4}), 32'h1A1);
        tap_sel3 = 2'd0; #1;
        check("tap3_s0", 32'({tap_valid3, tap_data3}), 32'h1D4);
        tap_sel3 = 2'd2; #1;
        check("tap3_s2", 32'({tap_valid3, tap_data3}), 32'h0B2);
        tap_sel3 = 2'd3; #1;
        check("tap3_oor", 32'({tap_valid3, tap_data3}), 32'h0);
        tap_sel2 = 1'b1; #1;
        check("tap2_s1", 32'({tap_valid2, tap_data2}), 32'h1C3);
        tap_sel2 = 1'b0;

        // Edge detection: out_data 0x0F then 0xF0
        flush = 1'b1; en = 1'b1; step(); flush = 1'b0;
        drive(8'h0F, 1'b1); step();
        drive(8'hF0, 1'b1); step();
        drive(8'h00, 1'b0);
        check("edge_first_out",  32'(out_data2), 32'h0F);
        check("edge_first_rise", 32'(rise2),     32'h0F);
        check("edge_first_fall", 32'(fall2),     32'h00);
        step();
        check("edge_out",  32'(out_data2), 32'hF0);
        check("edge_rise", 32'(rise2),     32'hF0);
        check("edge_fall", 32'(fall2),     32'h0F);

        // Asynchronous reset mid-cycle with a full pipe
        drive(8'h5A, 1'b1); step();
        drive(8'hC6, 1'b1); step();
        check("pre_arst_count", 32'(count2), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out",   32'({out_valid2, out_data2}), 32'h0);
        check("arst_count", 32'(count2), 32'd0);
        check("arst_tap",   32'({tap_valid2, tap_data2}), 32'h0);
        check("arst_edges", 32'({rise2, fall2}), 32'h0);
        check("arst_count4", 32'(count4), 32'd0);
        drive(8'h00, 1'b0);
        #1;
        rst_n = 1'b1;
        step();
        check("post_arst_out", 32'({out_valid2, out_data2}), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/delay_pipe.md
DELAY_PIPE -- requirements
Module: delay_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data bits per stage (legal 1..32).
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning register stages in the pipe (legal 1..16).
REQ-003 The block SHALL have derived constant SW = clog2(DEPTH) with minimum value 1, and CW = clog2(DEPTH+1).
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  advance strobe; when high the pipe shifts one stage.
REQ-008 flush  input  1  synchronous clear of all stages and history.
REQ-009 in_data  input  WIDTH  data entering stage 0.
REQ-010 in_valid  input  1  qualifier for in_data.
REQ-011 tap_sel  input  SW  stage index for the tap outputs (0 = first stage).
REQ-012 out_data  output  WIDTH  stage DEPTH-1 data.
REQ-013 out_valid  output  1  stage DEPTH-1 valid.
REQ-014 tap_data  output  WIDTH  data of stage tap_sel.
REQ-015 tap_valid  output  1  valid of stage tap_sel.
REQ-016 rise  output  WIDTH  per-bit 0->1 edge of out_data versus the history register.
REQ-017 fall  output  WIDTH  per-bit 1->0 edge of out_data versus the history register.
REQ-018 count  output  CW  number of stages whose valid bit is set.

Function
REQ-019 With en=1 and flush=0, stage 0 SHALL load {in_valid, in_data}, stage i SHALL load stage i-1, and hist SHALL load the pre-edge out_data, all on the same edge.
REQ-020 With en=0 and flush=0, every stage and hist SHALL hold its value.
REQ-021 Latency from in_data/in_valid sampled to out_data/out_valid SHALL be exactly DEPTH enabled cycles; with en tied high, DEPTH clock cycles.
REQ-022 When flush=1, every stage's data and valid and hist SHALL be zero after the edge, regardless of en; the input word presented that cycle is discarded.
REQ-023 Data SHALL shift regardless of in_valid; valid bits travel with their data and never gate the shift.
REQ-024 tap_data/tap_valid SHALL be combinational selects of stage tap_sel; tap_sel >= DEPTH SHALL yield tap_data=0 and tap_valid=0.
REQ-025 rise SHALL equal out_data & ~hist, and fall SHALL equal ~out_data & hist, both combinational.
REQ-026 count SHALL be a registered population count of stage valid bits, updated on the same edge as the stages, so it always matches the current valid bits.
REQ-027 When DEPTH=1, stage 0 SHALL be the output stage and tap_sel=0 SHALL select it.

Reset
REQ-028 On rst_n=0, all stages, valid bits, hist and count SHALL clear to zero asynchronously; out_data, out_valid, tap_*, rise, fall and count SHALL read 0.
REQ-029 Reset deassertion SHALL take effect on the next clk rising edge; reset asserted mid-stream SHALL discard all in-flight words.

Structure
REQ-030 Package delay_pipe_pkg SHALL hold the clog2 function, constants MAX_WIDTH=32 and MAX_DEPTH=16, and the stage record type {valid, data}.
REQ-031 The block SHALL use one sub-module, delay_stage, a single WIDTH+1-bit register with rst_n, en and flush, instantiated DEPTH times in a generate loop.

Verification
REQ-032 Scenario: with WIDTH=8, DEPTH=2, en=1, drive in_data=0xA5 and in_valid=1 for one cycle, then in_valid=0 -> out_data=0xA5 and out_valid=1 exactly 2 cycles later, and count goes 1,1,0.
REQ-033 Scenario: shift 0x11, 0x22, 0x33, then hold en=0 for 5 cycles -> outputs and count frozen; resuming en continues the sequence with nothing lost.
REQ-034 Scenario: with the pipe full of valid words, assert flush with en=1 and in_valid=1 -> next cycle count=0, out_valid=0, out_data=0, and the flushed input never emerges.
REQ-035 Scenario: with DEPTH=4, sweep tap_sel 0..3 with a known fill -> tap_data matches each stage; set tap_sel beyond range using DEPTH=3 and tap_sel=3 -> tap_data=0 and tap_valid=0.
REQ-036 Scenario: out_data goes 0x0F then 0xF0 with en=1 -> rise=0xF0 and fall=0x0F in the cycle after the change.
REQ-037 Scenario: pull rst_n low mid-clock with a full pipe -> all outputs read 0 immediately, before the next clk edge.
